// File: rtl/picorv32_lite_pkg.sv
// Shared constants and types for the picorv32_lite RV32I core.
package picorv32_lite_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LB   = 3'd0;
    localparam logic [2:0] F3_LH   = 3'd1;
    localparam logic [2:0] F3_LBU  = 3'd4;
    localparam logic [2:0] F3_LHU  = 3'd5;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEM   = 2'd2,
        ST_TRAP  = 2'd3
    } state_e;

    // Shift the addressed lane down to bit 0, then extend per load width.
    function automatic logic [XLEN-1:0] load_extract(input logic [2:0] f3, input logic [1:0] lane,
                                                     input logic [XLEN-1:0] word);
        logic [XLEN-1:0] sh;
        sh = word >> {lane, 3'b000};
        case (f3)
            F3_LB:   return {{24{sh[7]}}, sh[7:0]};
            F3_LH:   return {{16{sh[15]}}, sh[15:0]};
            F3_LBU:  return {24'b0, sh[7:0]};
            F3_LHU:  return {16'b0, sh[15:0]};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/picorv32_lite_if.sv
// picorv32 native memory bus: core is master, memory system is slave.
interface picorv32_lite_if;
    import picorv32_lite_pkg::*;

    logic            mem_valid;
    logic            mem_instr;
    logic            mem_ready;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wstrb;
    logic [XLEN-1:0] mem_rdata;

    modport master (output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                    output mem_ready, mem_rdata);
endinterface

// File: rtl/picorv32_lite_regs.sv
// 32x32 register file, two async read ports, one write port, x0 hard-wired to zero.
module picorv32_lite_regs
    import picorv32_lite_pkg::*;
#(
    parameter logic [XLEN-1:0] STACKADDR = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] rf [32];

    assign rf[0] = '0;

    for (genvar i = 1; i < 32; i++) begin : g_x
        logic [XLEN-1:0] x_q;
        if (i == 2) begin : g_sp
            // sp always takes STACKADDR; the all-ones "disabled" value is just an arbitrary start.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    x_q <= STACKADDR;
                end else if (we_i && waddr_i == 5'(i)) begin
                    x_q <= wdata_i;
                end
            end
        end else begin : g_gp
            always_ff @(posedge clk) begin
                if (we_i && waddr_i == 5'(i)) begin
                    x_q <= wdata_i;
                end
            end
        end
        assign rf[i] = x_q;
    end

    assign rdata1_o = rf[raddr1_i];
    assign rdata2_o = rf[raddr2_i];

endmodule

// File: rtl/picorv32_lite.sv
// Multi-cycle RV32I core on the picorv32 native memory bus, one instruction in flight.
//   state    | meaning
//   ST_FETCH | raise instruction request at PC, latch instruction on ready
//   ST_EXEC  | decode, ALU, branch/jump, writeback; launch load/store
//   ST_MEM   | hold data request until ready, write back load result
//   ST_TRAP  | halted, bus idle until reset
module picorv32_lite
    import picorv32_lite_pkg::*;
#(
    parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
    parameter logic [31:0] STACKADDR      = 32'hFFFF_FFFF,
    parameter bit          CATCH_MISALIGN = 1'b1,
    parameter bit          CATCH_ILLINSN  = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        trap,
    input  logic [31:0] irq,
    output logic [31:0] eoi,
    picorv32_lite_if.master bus
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, insn_q, insn_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            valid_q, valid_d, instr_q, instr_d;

    logic [6:0]      opc;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic            alt;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rs1_v, rs2_v, op_b, alu_y, ls_addr, target;
    logic            rf_we, taken, jump, fault, ls_misalign, unused_irq;
    logic [XLEN-1:0] rf_wdata;

    assign opc   = insn_q[6:0];
    assign rd    = insn_q[11:7];
    assign f3    = insn_q[14:12];
    assign rs1   = insn_q[19:15];
    assign rs2   = insn_q[24:20];
    assign alt   = insn_q[30];
    assign imm_i = {{20{insn_q[31]}}, insn_q[31:20]};
    assign imm_s = {{20{insn_q[31]}}, insn_q[31:25], insn_q[11:7]};
    assign imm_b = {{19{insn_q[31]}}, insn_q[31], insn_q[7], insn_q[30:25], insn_q[11:8], 1'b0};
    assign imm_u = {insn_q[31:12], 12'b0};
    assign imm_j = {{11{insn_q[31]}}, insn_q[31], insn_q[19:12], insn_q[20], insn_q[30:21], 1'b0};

    picorv32_lite_regs #(.STACKADDR(STACKADDR)) u_regs (
        .clk      (clk),
        .rst_n    (resetn),
        .we_i     (rf_we),
        .waddr_i  (rd),
        .wdata_i  (rf_wdata),
        .raddr1_i (rs1),
        .raddr2_i (rs2),
        .rdata1_o (rs1_v),
        .rdata2_o (rs2_v)
    );

    assign op_b = (opc == OPC_OP) ? rs2_v : imm_i;

    always_comb begin
        case (f3)
            F3_ADD:  alu_y = (opc == OPC_OP && alt) ? rs1_v - op_b : rs1_v + op_b;
            F3_SLL:  alu_y = rs1_v << op_b[4:0];
            F3_SLT:  alu_y = {31'b0, $signed(rs1_v) < $signed(op_b)};
            F3_SLTU: alu_y = {31'b0, rs1_v < op_b};
            F3_XOR:  alu_y = rs1_v ^ op_b;
            F3_SR:   alu_y = alt ? 32'($signed(rs1_v) >>> op_b[4:0]) : rs1_v >> op_b[4:0];
            F3_OR:   alu_y = rs1_v | op_b;
            default: alu_y = rs1_v & op_b;
        endcase
    end

    always_comb begin
        case (f3)
            F3_BEQ:  taken = (rs1_v == rs2_v);
            F3_BNE:  taken = (rs1_v != rs2_v);
            F3_BLT:  taken = ($signed(rs1_v) < $signed(rs2_v));
            F3_BGE:  taken = ($signed(rs1_v) >= $signed(rs2_v));
            F3_BLTU: taken = (rs1_v < rs2_v);
            F3_BGEU: taken = (rs1_v >= rs2_v);
            default: taken = 1'b0;
        endcase
    end

    // Registers are untouched between EXEC and MEM, so the address stays valid for lane selection.
    assign ls_addr     = rs1_v + ((opc == OPC_STORE) ? imm_s : imm_i);
    assign ls_misalign = (f3[1:0] == 2'b01 && ls_addr[0]) || (f3[1:0] == 2'b10 && ls_addr[1:0] != 2'b00);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_FETCH;
            pc_q    <= PROGADDR_RESET;
            insn_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            valid_q <= 1'b0;
            instr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            insn_q  <= insn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        insn_d   = insn_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        rf_we    = 1'b0;
        rf_wdata = alu_y;
        target   = '0;
        jump     = 1'b0;
        fault    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    instr_d = 1'b1;
                    addr_d  = pc_q;
                    wstrb_d = 4'b0000;
                end else if (bus.mem_ready) begin
                    valid_d = 1'b0;
                    instr_d = 1'b0;
                    insn_d  = bus.mem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                pc_d    = pc_q + 32'd4;
                case (opc)
                    OPC_LUI: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm_u;
                    end
                    OPC_AUIPC: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_q + imm_u;
                    end
                    OPC_JAL, OPC_JALR: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_q + 32'd4;
                        jump     = 1'b1;
                        target   = (opc == OPC_JAL) ? pc_q + imm_j : (rs1_v + imm_i) & ~32'd1;
                    end
                    OPC_BRANCH: begin
                        jump   = taken;
                        target = pc_q + imm_b;
                    end
                    OPC_OP, OPC_OPIMM: rf_we = 1'b1;
                    OPC_LOAD, OPC_STORE: begin
                        fault   = CATCH_MISALIGN && ls_misalign;
                        valid_d = 1'b1;
                        addr_d  = {ls_addr[31:2], 2'b00};
                        wstrb_d = 4'b0000;
                        state_d = ST_MEM;
                        if (opc == OPC_STORE) begin
                            case (f3[1:0])
                                2'b00: begin
                                    wstrb_d = 4'b0001 << ls_addr[1:0];
                                    wdata_d = {4{rs2_v[7:0]}};
                                end
                                2'b01: begin
                                    wstrb_d = ls_addr[1] ? 4'b1100 : 4'b0011;
                                    wdata_d = {2{rs2_v[15:0]}};
                                end
                                default: begin
                                    wstrb_d = 4'b1111;
                                    wdata_d = rs2_v;
                                end
                            endcase
                        end
                    end
                    OPC_FENCE:  ;
                    OPC_SYSTEM: fault = 1'b1;
                    default:    fault = CATCH_ILLINSN;
                endcase
                if (jump) begin
                    pc_d = target;
                    if (CATCH_MISALIGN && target[1:0] != 2'b00) fault = 1'b1;
                end
                if (fault) begin
                    state_d = ST_TRAP;
                    rf_we   = 1'b0;
                    valid_d = 1'b0;
                    wstrb_d = 4'b0000;
                end
            end
            ST_MEM: begin
                if (bus.mem_ready) begin
                    valid_d = 1'b0;
                    wstrb_d = 4'b0000;
                    state_d = ST_FETCH;
                    if (wstrb_q == 4'b0000) begin
                        rf_we    = 1'b1;
                        rf_wdata = load_extract(f3, ls_addr[1:0], bus.mem_rdata);
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                instr_d = 1'b0;
            end
        endcase
    end

    assign bus.mem_valid = valid_q;
    assign bus.mem_instr = instr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wstrb = wstrb_q;
    assign trap          = (state_q == ST_TRAP);
    assign eoi           = '0;
    assign unused_irq    = ^irq;

endmodule

// File: tb/tb_picorv32_lite.sv
// Directed bench for picorv32_lite: small hand-assembled programs, MMIO store log, wait-state memory model.
module tb_picorv32_lite;

    logic        clk;
    logic        resetn;
    logic        trap;
    logic [31:0] irq;
    logic [31:0] eoi;

    picorv32_lite_if bus ();

    picorv32_lite #(
        .PROGADDR_RESET (32'h0000_0000),
        .STACKADDR      (32'h0002_0000),
        .CATCH_MISALIGN (1'b1),
        .CATCH_ILLINSN  (1'b1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .trap   (trap),
        .irq    (irq),
        .eoi    (eoi),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] ram [256];
    int          wait_cyc;
    int          n_data;
    int          stab_err;
    logic [31:0] fa [$];
    logic [31:0] st_a [$];
    logic [31:0] st_d [$];
    logic [3:0]  st_s [$];

    logic [31:0] exp_d [12] = '{32'h0002_0000, 32'h4848_4848, 32'h0000_0014, 32'hFFFF_FF80,
                                32'h0000_0080, 32'hFFFF_8000, 32'h0000_0009, 32'h0000_0002,
                                32'hF800_0000, 32'h0000_0001, 32'h0000_0000, 32'h0002_0002};
    logic [3:0]  exp_s [12] = '{4'hF, 4'h1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hC};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] i_t(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] opc);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), 3'(f3), 5'(rd), opc};
    endfunction

    function automatic logic [31:0] s_t(input int imm, input int rs2, input int rs1, input int f3);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] b_t(input int imm, input int rs2, input int rs1, input int f3);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] j_t(input int imm, input int rd);
        logic [20:0] im;
        im = 21'(imm);
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6F};
    endfunction

    function automatic logic [31:0] r_t(input int f7, input int rs2, input int rs1, input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    // Memory model: ready driven on the falling edge, wait_cyc idle cycles before each ready.
    initial begin : responder
        logic        busy;
        int          wcnt;
        logic [31:0] s_addr, s_wdata;
        logic [3:0]  s_wstrb;
        logic        s_instr;
        logic [7:0]  idx;
        busy = 1'b0;
        wcnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (!resetn || !bus.mem_valid) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy    = 1'b1;
                    wcnt    = 0;
                    s_addr  = bus.mem_addr;
                    s_wdata = bus.mem_wdata;
                    s_wstrb = bus.mem_wstrb;
                    s_instr = bus.mem_instr;
                end else if (bus.mem_addr !== s_addr || bus.mem_wdata !== s_wdata ||
                             bus.mem_wstrb !== s_wstrb || bus.mem_instr !== s_instr) begin
                    stab_err++;
                end
                if (wcnt >= wait_cyc) begin
                    busy = 1'b0;
                    idx  = bus.mem_addr[9:2];
                    if (bus.mem_instr) fa.push_back(bus.mem_addr);
                    else n_data++;
                    if (bus.mem_addr < 32'h400) begin
                        bus.mem_rdata = ram[idx];
                        for (int b = 0; b < 4; b++)
                            if (bus.mem_wstrb[b]) ram[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
                    end else begin
                        bus.mem_rdata = '0;
                        if (bus.mem_wstrb != 4'b0000) begin
                            st_a.push_back(bus.mem_addr);
                            st_s.push_back(bus.mem_wstrb);
                            st_d.push_back(bus.mem_wdata);
                        end
                    end
                    bus.mem_ready = 1'b1;
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic clear_logs();
        fa.delete();
        st_a.delete();
        st_s.delete();
        st_d.delete();
        n_data   = 0;
        stab_err = 0;
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.mem_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_seen"}, 32'(bus.mem_valid), 32'd1);
    endtask

    task automatic wait_trap(input string tag, input int budget);
        int n;
        n = 0;
        while (!trap && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_trap_seen"}, 32'(trap), 32'd1);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.mem_valid) n++;
        end
        chk({tag, "_idle_after_trap"}, 32'(n), 32'd0);
    endtask

    task automatic check_run(input string tag);
        chk({tag, "_nfetch"}, 32'(fa.size()), 32'd34);
        chk({tag, "_ndata"}, 32'(n_data), 32'd15);
        chk({tag, "_nstore"}, 32'(st_d.size()), 32'd12);
        if (fa.size() > 5) chk({tag, "_jal_next"}, fa[5], 32'h18);
        for (int i = 0; i < 12 && i < st_d.size(); i++) begin
            chk($sformatf("%s_st%0d_addr", tag, i), st_a[i], 32'h2000_0000);
            chk($sformatf("%s_st%0d_strb", tag, i), 32'(st_s[i]), 32'(exp_s[i]));
            chk($sformatf("%s_st%0d_data", tag, i), st_d[i], exp_d[i]);
        end
    endtask

    task automatic hold_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic load_main_prog();
        for (int i = 0; i < 256; i++) ram[i] = 32'h0000_0013;
        ram[0]  = {20'h20000, 5'd6, 7'h37};
        ram[1]  = s_t(0, 2, 6, 2);
        ram[2]  = i_t(72, 0, 0, 5, 7'h13);
        ram[3]  = s_t(0, 5, 6, 0);
        ram[4]  = j_t(8, 1);
        ram[5]  = 32'h0010_0073;
        ram[6]  = s_t(0, 1, 6, 2);
        ram[7]  = i_t(256, 0, 0, 7, 7'h13);
        ram[8]  = i_t(1, 7, 0, 8, 7'h03);
        ram[9]  = s_t(0, 8, 6, 2);
        ram[10] = i_t(1, 7, 4, 8, 7'h03);
        ram[11] = s_t(0, 8, 6, 2);
        ram[12] = i_t(0, 7, 1, 8, 7'h03);
        ram[13] = s_t(0, 8, 6, 2);
        ram[14] = i_t(-1, 0, 0, 9, 7'h13);
        ram[15] = i_t(1, 0, 0, 10, 7'h13);
        ram[16] = i_t(0, 0, 0, 11, 7'h13);
        ram[17] = b_t(8, 10, 9, 6);
        ram[18] = i_t(1, 11, 6, 11, 7'h13);
        ram[19] = b_t(8, 10, 9, 4);
        ram[20] = i_t(2, 11, 6, 11, 7'h13);
        ram[21] = b_t(8, 10, 10, 0);
        ram[22] = i_t(4, 11, 6, 11, 7'h13);
        ram[23] = b_t(8, 10, 9, 0);
        ram[24] = i_t(8, 11, 6, 11, 7'h13);
        ram[25] = s_t(0, 11, 6, 2);
        ram[26] = r_t(32, 9, 10, 0, 12);
        ram[27] = s_t(0, 12, 6, 2);
        ram[28] = {20'h80000, 5'd14, 7'h37};
        ram[29] = i_t(32'h404, 14, 5, 13, 7'h13);
        ram[30] = s_t(0, 13, 6, 2);
        ram[31] = r_t(0, 10, 9, 2, 15);
        ram[32] = s_t(0, 15, 6, 2);
        ram[33] = r_t(0, 10, 9, 3, 16);
        ram[34] = s_t(0, 16, 6, 2);
        ram[35] = s_t(2, 12, 6, 1);
        ram[36] = 32'h0010_0073;
        ram[64] = 32'h0000_8000;
    endtask

    initial begin : main
        int n;
        irq      = '0;
        resetn   = 1'b0;
        wait_cyc = 0;
        n_data   = 0;
        stab_err = 0;
        load_main_prog();
        repeat (3) @(negedge clk);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_instr", 32'(bus.mem_instr), 32'd0);
        chk("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst_eoi", eoi, 32'd0);

        resetn = 1'b1;
        wait_req("first", 20);
        chk("first_addr", bus.mem_addr, 32'h0);
        chk("first_instr", 32'(bus.mem_instr), 32'd1);
        chk("first_wstrb", 32'(bus.mem_wstrb), 32'd0);
        wait_trap("zw", 3000);
        check_run("zw");

        hold_reset();
        clear_logs();
        wait_cyc = 5;
        resetn   = 1'b1;
        wait_trap("ws", 6000);
        check_run("ws");
        chk("ws_stable", 32'(stab_err), 32'd0);

        hold_reset();
        clear_logs();
        wait_cyc = 0;
        ram[0] = i_t(32'h102, 0, 0, 7, 7'h13);
        ram[1] = i_t(0, 7, 2, 8, 7'h03);
        ram[2] = s_t(0, 8, 6, 2);
        resetn = 1'b1;
        wait_trap("lwmis", 500);
        chk("lwmis_ndata", 32'(n_data), 32'd0);
        chk("lwmis_nfetch", 32'(fa.size()), 32'd2);

        hold_reset();
        chk("rst2_trap", 32'(trap), 32'd0);
        clear_logs();
        wait_cyc = 5;
        resetn   = 1'b1;
        n = 0;
        while (!(bus.mem_valid && bus.mem_instr && bus.mem_addr == 32'h4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("mid_fetch_seen", bus.mem_addr, 32'h4);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("abort_valid", 32'(bus.mem_valid), 32'd0);
        chk("abort_trap", 32'(trap), 32'd0);
        #4 resetn = 1'b1;
        @(negedge clk);
        wait_req("refetch", 20);
        chk("refetch_addr", bus.mem_addr, 32'h0);
        chk("refetch_instr", 32'(bus.mem_instr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
